// File: rtl/alu_pkg.sv
// Shared ALU definitions: command encoding, operand-stage sizing, issue payload
// and command-class helpers used by the ALU, the decoder and the operand stage.
package alu_pkg;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = $clog2(NREG);
  localparam int unsigned CW   = 4;

  typedef enum logic [CW-1:0] {
    CMD_AND   = 4'd0,
    CMD_XOR   = 4'd1,
    CMD_OR    = 4'd2,
    CMD_LSL   = 4'd3,
    CMD_LSR   = 4'd4,
    CMD_ADD   = 4'd5,
    CMD_SUB   = 4'd6,
    CMD_PASSA = 4'd7
  } alu_cmd_e;

  // Contents of the issue register feeding the combinational ALU
  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] ra;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
  } iss_t;

  // Commands 0-7 write their result back; 8-15 are undefined and write nothing
  function automatic logic cmd_writes(input logic [CW-1:0] cmd);
    return !cmd[CW-1];
  endfunction

  // Shifts and add/sub both consume and produce the carry flag
  function automatic logic cmd_uses_carry(input logic [CW-1:0] cmd);
    return (cmd >= CMD_LSL) && (cmd <= CMD_SUB);
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decoded-operation handshake plus the operand/result bus to the ALU.
// master = decoder and ALU side, slave = operand stage.
interface alu_operand_stage_if;
  import alu_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_cmd;
  logic [AW-1:0] in_ra;
  logic [AW-1:0] in_rb;
  logic          in_bsel;
  logic [DW-1:0] in_imm;
  logic          hold;

  logic [CW-1:0] alu_cmd;
  logic [DW-1:0] alu_inA;
  logic [DW-1:0] alu_inB;
  logic          alu_shiftcarry_in;
  logic [DW-1:0] alu_rslt;
  logic          alu_shiftcarry_out;

  modport master (
    output in_valid, in_cmd, in_ra, in_rb, in_bsel, in_imm, hold,
    output alu_rslt, alu_shiftcarry_out,
    input  in_ready, alu_cmd, alu_inA, alu_inB, alu_shiftcarry_in
  );

  modport slave (
    input  in_valid, in_cmd, in_ra, in_rb, in_bsel, in_imm, hold,
    input  alu_rslt, alu_shiftcarry_out,
    output in_ready, alu_cmd, alu_inA, alu_inB, alu_shiftcarry_in
  );

endinterface

// File: rtl/alu_regfile.sv
// NREG x DW register file: two operand read ports, one debug read port,
// one synchronous write port, synchronous clear on reset.
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];

  always_comb begin
    rf_d = rf_q;
    if (we) rf_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rf_q <= '{default: '0};
    else       rf_q <= rf_d;
  end

  // Reads see the pre-write value; no write-through
  assign ra_data  = rf_q[ra_addr];
  assign rb_data  = rf_q[rb_addr];
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch / writeback stage in front of the combinational ALU.
// ALU_OPSTAGE_BYPASS_EN: forward the in-flight result/carry instead of interlocking.
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  alu_operand_stage_if.slave bus,
  output logic          wb_valid,
  output logic          carry_flag,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  iss_t          iss_q, iss_d;
  logic          iss_valid_q, iss_valid_d;
  logic          carry_q, carry_d;
  logic          wb_valid_q, wb_valid_d;

  logic [DW-1:0] ra_data, rb_data;
  logic [DW-1:0] op_a, op_b;
  logic          op_cin;
  logic          pend_wr, pend_cy;
  logic          hit_a, hit_b;
`ifdef ALU_OPSTAGE_BYPASS_EN
`else
  logic          hit_c;
`endif
  logic          stall, in_ready_c, accept;

  alu_regfile u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (pend_wr),
    .waddr    (iss_q.ra),
    .wdata    (bus.alu_rslt),
    .ra_addr  (bus.in_ra),
    .ra_data  (ra_data),
    .rb_addr  (bus.in_rb),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Hazard detection, operand selection and next-state for issue/carry
  always_comb begin
    iss_d       = iss_q;
    iss_valid_d = 1'b0;
    wb_valid_d  = 1'b0;
    carry_d     = carry_q;

    pend_wr = iss_valid_q && cmd_writes(iss_q.cmd);
    pend_cy = iss_valid_q && cmd_uses_carry(iss_q.cmd);
    hit_a   = pend_wr && (bus.in_ra == iss_q.ra);
    hit_b   = pend_wr && !bus.in_bsel && (bus.in_rb == iss_q.ra);

`ifdef ALU_OPSTAGE_BYPASS_EN
    stall  = 1'b0;
    op_a   = hit_a ? bus.alu_rslt : ra_data;
    op_b   = bus.in_bsel ? bus.in_imm : (hit_b ? bus.alu_rslt : rb_data);
    op_cin = pend_cy ? bus.alu_shiftcarry_out : carry_q;
`else
    // One-cycle interlock: the pending op drains, then the file/flag are current
    hit_c  = pend_cy && cmd_uses_carry(bus.in_cmd);
    stall  = hit_a || hit_b || hit_c;
    op_a   = ra_data;
    op_b   = bus.in_bsel ? bus.in_imm : rb_data;
    op_cin = carry_q;
`endif

    in_ready_c = !bus.hold && !stall;
    accept     = bus.in_valid && in_ready_c;

    if (accept) begin
      iss_d.cmd   = bus.in_cmd;
      iss_d.ra    = bus.in_ra;
      iss_d.a     = op_a;
      iss_d.b     = op_b;
      iss_d.cin   = op_cin;
      iss_valid_d = 1'b1;
      wb_valid_d  = cmd_writes(bus.in_cmd);
    end

    if (pend_cy) carry_d = bus.alu_shiftcarry_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_q       <= '0;
      iss_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      iss_q       <= iss_d;
      iss_valid_q <= iss_valid_d;
      carry_q     <= carry_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  assign bus.in_ready          = in_ready_c;
  assign bus.alu_cmd           = iss_q.cmd;
  assign bus.alu_inA           = iss_q.a;
  assign bus.alu_inB           = iss_q.b;
  assign bus.alu_shiftcarry_in = iss_q.cin;
  assign wb_valid              = wb_valid_q;
  assign carry_flag            = carry_q;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch and writeback stage placed directly upstream of the 8-bit `alu`. It accepts decoded operations over a valid/ready handshake, reads operands from an internal register file, and registers `alu_cmd`/`inA`/`inB`/`shiftcarry_in` into an issue register that drives the combinational ALU. On the following edge it writes `rslt` back to the register file and captures `shiftcarry_out` into a carry flag.

## Interface
- `DW`, 8, data width; matches ALU operand width.
- `NREG`, 8, register-file depth; `AW = $clog2(NREG)`.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decoded operation present.
- `in_ready`  out  1  stage accepts operation this cycle (combinational).
- `in_cmd`  in  4  ALU command: 0 AND, 1 XOR, 2 OR, 3 LSL, 4 LSR, 5 ADD, 6 SUB, 7 PASS A, 8–15 undefined.
- `in_ra`  in  AW  operand A source and destination register.
- `in_rb`  in  AW  operand B source register.
- `in_bsel`  in  1  1: operand B = `in_imm`; 0: operand B = `rf[in_rb]`.
- `in_imm`  in  DW  immediate operand B.
- `hold`  in  1  downstream stall; forces `in_ready` = 0.
- `alu_cmd`  out  4  to ALU `alu_cmd`.
- `alu_inA`  out  DW  to ALU `inA`.
- `alu_inB`  out  DW  to ALU `inB`.
- `alu_shiftcarry_in`  out  1  to ALU `shiftcarry_in`.
- `alu_rslt`  in  DW  from ALU `rslt`.
- `alu_shiftcarry_out`  in  1  from ALU `shiftcarry_out`.
- `wb_valid`  out  1  high in the cycle whose closing edge writes the register file.
- `carry_flag`  out  1  architectural carry flag.
- `dbg_addr`  in  AW  debug read address.
- `dbg_data`  out  DW  `rf[dbg_addr]`, combinational.

## Operation
- Accept on an edge where `in_valid && in_ready`. The issue register captures cmd, ra, operand A, operand B, and carry-in, and sets `iss_valid` = 1. With no accept, `iss_valid` clears to 0 at the next edge.
- ALU outputs come directly from the issue register. When idle, they hold their last issued values.
- Writing class: cmd 0–7 write `rf[iss_ra] <= alu_rslt` when `iss_valid`. `wb_valid` = `iss_valid && cmd<8`.
- Carry class: cmd 3–6 update `carry_flag <= alu_shiftcarry_out` and consume carry. All other cmds leave the flag unchanged.
- Undefined cmd 8–15: accepted and issued. No register write, no carry update, `wb_valid` = 0.
- Hazard: the accepted operation reads `iss_ra` while the issued operation writes it, or it consumes carry while the issued operation updates it. Resolution is set by the macro (see Configuration).
- `hold` never blocks the pending writeback; the issue register always drains.
- Reset: all `rf` entries = 0, `carry_flag` = 0, `iss_valid` = 0, `alu_cmd`/`alu_inA`/`alu_inB`/`alu_shiftcarry_in` = 0, `wb_valid` = 0. `in_ready` = 1 once `hold` = 0. Asserting `reset` while `iss_valid` = 1 discards the pending operation: no write, no carry update.

## Timing
- Accept at edge E → ALU inputs valid during cycle E..E+1 → register file and carry updated at E+1 → visible on `dbg_data`/`carry_flag` after E+1.
- Throughput is one operation per cycle when there is no stall.
- A write to the same register as `dbg_addr` at edge E+1 is visible on `dbg_data` only after that edge; there is no write-through on the debug port.

## Configuration
- `ALU_OPSTAGE_BYPASS_EN` defined:
  - Operands captured at accept use `alu_rslt` when the source register equals the pending destination.
  - Carry-in uses `alu_shiftcarry_out` when the pending operation updates carry.
  - `in_ready` = `!hold`.
- Undefined:
  - No forwarding.
  - On a hazard, `in_ready` = 0 for exactly one cycle (interlock). The operation is then accepted with file/flag values.
  - Architectural results are identical to the defined case; only cycle count differs.

## Structure
- Package `alu_pkg`: 4-bit command enum matching the ALU encoding, plus helper functions `cmd_writes(cmd)` and `cmd_uses_carry(cmd)`, shared with `alu` and the decoder.
- One sub-module, `alu_regfile`: NREG×DW, two combinational read ports plus the debug port, one synchronous write port, synchronous reset clear.

## Test plan
- Reset with `hold` = 0 → `in_ready` = 1, `wb_valid` = 0, `carry_flag` = 0, `dbg_data` = 0x00 for all addresses.
- Back-to-back OR r1,imm 0xAA then OR r2,imm 0x55 (bench ALU model) → `wb_valid` high two consecutive cycles; r1 = 0xAA, r2 = 0x55.
- ADD r1,r2 immediately after the r2 load → `alu_inB` = 0x55, r1 = 0xFF. With the macro: no stall. Without the macro: `in_ready` low exactly one cycle.
- Model drives `alu_shiftcarry_out` = 1 on SUB, then AND, then ADD issued back-to-back:
  - `carry_flag` = 1 after SUB and stays 1 through AND.
  - ADD issues with `alu_shiftcarry_in` = 1.
- cmd 4'b1010 on r3 = 0x11 → accepted, `wb_valid` = 0, r3 stays 0x11, `carry_flag` unchanged.
- `hold` = 1 with `in_valid` = 1 while an op is issued → `in_ready` = 0 and the issued op still writes. Separately, `reset` asserted with `iss_valid` = 1 → no write, all registers 0.
